step_ramp_gen: RTL and testbench
================================

# step_ramp_gen

Parametrised step-pulse generator for the stepper motor controller. It replaces the fixed-rate step clock divider with a move engine. The engine accepts a step count, a direction and a speed profile. It then emits a trapezoidal (accelerate / cruise / decelerate) train of fixed-width step pulses to the motor driver stage, and signals completion. Supports a controlled abort: the move stops early through a deceleration ramp.

## Interface
- `CNT_W`, default 26: width of period arithmetic. A period is the number of clk cycles per step.
- `STEP_W`, default 16: width of step count and ramp counters.
- `PULSE_W`, default 16: step pulse high time, in clk cycles (≥1).
- `clk`  in  1  system clock. All logic on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `start`  in  1  move request. Sampled only in IDLE.
- `dir_in`  in  1  direction for the requested move.
- `num_steps`  in  STEP_W  steps in the move. 0 means the request is ignored.
- `period_init`  in  CNT_W  start/stop period.
- `period_min`  in  CNT_W  cruise (fastest) period.
- `period_dec`  in  CNT_W  period change per step while ramping. 0 means constant speed.
- `abort`  in  1  request decelerate-and-stop. Sampled only while busy.
- `step`  out  1  step pulse to driver.
- `dir`  out  1  direction, latched for the whole move.
- `busy`  out  1  move in progress.
- `done`  out  1  one-cycle pulse at move end.
- `step_count`  out  STEP_W  steps completed in current/last move.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL.
- Internal registers:
  - `cur_period` (CNT_W)
  - interval counter `cnt` (CNT_W)
  - `ramp_steps` (STEP_W)
  - latched `num_steps`, `period_init`, `period_min`, `period_dec`
- Start acceptance: `start` in IDLE with `num_steps`≠0 →
  - latch all inputs, `dir`←`dir_in`, `step_count`←0, `ramp_steps`←0, `cnt`←0.
  - `cur_period`←max(`period_init`, `period_min`).
  - Next state: CRUISE if `cur_period`==`period_min`, else ACCEL.
- Effective interval length: `eff` = max(`cur_period`, `PULSE_W`+1).
- Per interval:
  - `step`=1 while `cnt`<`PULSE_W`, else 0.
  - `cnt` counts 0..`eff`−1.
- Interval end (`cnt`==`eff`−1): `cnt`←0 and `n`=`step_count`+1 is written. Then:
  - `n`==`num_steps` → finish.
  - DECEL with `ramp_steps`==0 → finish.
  - ACCEL/CRUISE with (`num_steps`−`n`) ≤ `ramp_steps` → go to DECEL and apply the DECEL update below.
  - ACCEL otherwise → `cur_period`←max(`cur_period`−`period_dec`, `period_min`), no underflow; `ramp_steps`++. Go to CRUISE when the new period equals `period_min`.
  - CRUISE otherwise → no change.
  - DECEL update → `cur_period`←min(`cur_period`+`period_dec`, `period_init`), computed at CNT_W+1 bits with no overflow; `ramp_steps`−−, saturating at 0.
- Finish: next cycle `done`=1, `busy`=0, state IDLE. `step_count` holds its value until the next accepted start.
- Abort: `abort`=1 in ACCEL/CRUISE → state DECEL on the next edge. The current interval completes at its current length. The ramp retraces the steps taken, so the profile stays symmetric. `abort` in DECEL/IDLE is ignored.
- Simultaneous events:
  - `start` while busy: ignored.
  - `start`+`abort` in IDLE: start accepted.
  - `abort` on the finishing interval end: finish wins.
  - Input changes during a move: ignored.

## Timing
- Reset values: `step`=0, `dir`=0, `busy`=0, `done`=0, `step_count`=0, state IDLE, all counters 0.
- `rst` mid-move: all of the above take effect on the next edge. No trailing pulse and no `done`.
- Start accepted at edge T (cycle 0):
  - `busy`=1 and `step` rises in cycle 1. The first interval occupies cycles 1..`eff`.
- Step k rises exactly `eff`(k−1) cycles after step k−1.
- `done` is high in the cycle after the last interval's final cycle. `busy` falls in that same cycle.
- Back-to-back moves: `start` may be asserted in the `done` cycle. It is accepted, and the new move begins the cycle after.
- All outputs are registered.

## Test plan
- Constant speed: `PULSE_W`=2, `num_steps`=4, `period_init`=`period_min`=10, `period_dec`=0, start at cycle 0 → `step` high cycles 1-2, 11-12, 21-22, 31-32; `done`=1 at cycle 41; `step_count`=4.
- Trapezoid: `period_init`=20, `period_min`=10, `period_dec`=5, `num_steps`=6 → intervals 20, 15, 10, 10, 15, 20; step rises at 1, 21, 36, 46, 56, 71; `done` at 91.
- Abort in cruise: same profile, `num_steps`=100, `abort` during the 3rd interval → intervals 20, 15, 10, 15, 20; `step_count`=5; `done` at 81. Abort in the 1st interval → 1 step, `done` at 21.
- Short move with no cruise: same profile, `num_steps`=3 → intervals 20, 15, 20; `done` at 56. Also `num_steps`=0 → no `busy`, no pulses.
- Clamps: `period_init`=5, `period_min`=8 → all intervals 8. `PULSE_W`=4 with `period_min`=3 → intervals 5. `period_dec` larger than `period_init` → no wrap, period goes straight to `period_min`.
- Reset and handshake: `rst` during the 2nd pulse → `step`/`busy` low next edge, no `done`. `start` while busy → ignored. `start` in the `done` cycle → new move begins the next cycle.

Source files
------------

// File: rtl/step_ramp_gen_if.sv
// Move-request / step-output bundle between the motion controller and step_ramp_gen.
// The master side issues moves; the slave side (the generator) drives step, dir and status.
interface step_ramp_gen_if #(
    parameter int unsigned CNT_W  = 26,
    parameter int unsigned STEP_W = 16
);
    logic              start;
    logic              dir_in;
    logic [STEP_W-1:0] num_steps;
    logic [CNT_W-1:0]  period_init;
    logic [CNT_W-1:0]  period_min;
    logic [CNT_W-1:0]  period_dec;
    logic              abort;
    logic              step;
    logic              dir;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step_count;

    modport master (
        output start, dir_in, num_steps, period_init, period_min, period_dec, abort,
        input  step, dir, busy, done, step_count
    );

    modport slave (
        input  start, dir_in, num_steps, period_init, period_min, period_dec, abort,
        output step, dir, busy, done, step_count
    );
endinterface

// File: rtl/step_ramp_gen.sv
// Trapezoidal step-pulse move engine: accelerate, cruise, decelerate, with controlled abort.
// Each step is one interval of max(cur_period, PULSE_W+1) clocks, pulse high for PULSE_W clocks.
module step_ramp_gen #(
    parameter int unsigned CNT_W   = 26,
    parameter int unsigned STEP_W  = 16,
    parameter int unsigned PULSE_W = 16
) (
    input logic            clk,
    input logic            rst,
    step_ramp_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] PulseLen = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] MinEff   = CNT_W'(PULSE_W + 1);

    typedef enum logic [1:0] {StIdle, StAccel, StCruise, StDecel} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cur_period_q, cur_period_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] ramp_q, ramp_d;
    logic [STEP_W-1:0] num_q, num_d;
    logic [STEP_W-1:0] count_q, count_d;
    logic [CNT_W-1:0]  init_q, init_d;
    logic [CNT_W-1:0]  min_q, min_d;
    logic [CNT_W-1:0]  dec_q, dec_d;
    logic              step_q, step_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  eff, start_period, period_up, period_down;
    logic [CNT_W:0]    up_sum;
    logic [STEP_W-1:0] n_next, ramp_dn;
    logic              interval_end, finish;

    always_comb begin
        eff          = (cur_period_q > MinEff) ? cur_period_q : MinEff;
        interval_end = (cnt_q == eff - CNT_W'(1));
        n_next       = count_q + STEP_W'(1);
        ramp_dn      = (ramp_q != '0) ? ramp_q - STEP_W'(1) : '0;
        start_period = (bus.period_init > bus.period_min) ? bus.period_init : bus.period_min;
        // Compare the headroom first so the subtraction can never wrap below period_min.
        period_down  = (cur_period_q - min_q > dec_q) ? cur_period_q - dec_q : min_q;
        up_sum       = {1'b0, cur_period_q} + {1'b0, dec_q};
        period_up    = (up_sum > {1'b0, init_q}) ? init_q : up_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d      = state_q;
        cur_period_d = cur_period_q;
        cnt_d        = cnt_q;
        ramp_d       = ramp_q;
        num_d        = num_q;
        count_d      = count_q;
        init_d       = init_q;
        min_d        = min_q;
        dec_d        = dec_q;
        dir_d        = dir_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        step_d       = 1'b0;
        finish       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && bus.num_steps != '0) begin
                    state_d      = (start_period == bus.period_min) ? StCruise : StAccel;
                    num_d        = bus.num_steps;
                    init_d       = bus.period_init;
                    min_d        = bus.period_min;
                    dec_d        = bus.period_dec;
                    dir_d        = bus.dir_in;
                    cur_period_d = start_period;
                    count_d      = '0;
                    ramp_d       = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    step_d       = 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (interval_end) begin
                    cnt_d   = '0;
                    count_d = n_next;
                    if (n_next == num_q || (state_q == StDecel && ramp_q == '0)) begin
                        finish = 1'b1;
                    end else if (state_q != StDecel && (num_q - n_next) <= ramp_q) begin
                        state_d      = StDecel;
                        cur_period_d = period_up;
                        ramp_d       = ramp_dn;
                    end else if (state_q == StAccel) begin
                        cur_period_d = period_down;
                        ramp_d       = ramp_q + STEP_W'(1);
                        if (period_down == min_q) state_d = StCruise;
                    end else if (state_q == StDecel) begin
                        cur_period_d = period_up;
                        ramp_d       = ramp_dn;
                    end
                end
                if (finish) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // Abort only redirects the profile; the running interval keeps its length.
                    if (bus.abort && state_q != StDecel) state_d = StDecel;
                    step_d = (cnt_d < PulseLen);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_period_q <= '0;
            cnt_q        <= '0;
            ramp_q       <= '0;
            num_q        <= '0;
            count_q      <= '0;
            init_q       <= '0;
            min_q        <= '0;
            dec_q        <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_period_q <= cur_period_d;
            cnt_q        <= cnt_d;
            ramp_q       <= ramp_d;
            num_q        <= num_d;
            count_q      <= count_d;
            init_q       <= init_d;
            min_q        <= min_d;
            dec_q        <= dec_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.step       = step_q;
    assign bus.dir        = dir_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.step_count = count_q;
endmodule

// File: tb/tb_step_ramp_gen.sv
// Bench for step_ramp_gen: two instances (pulse widths 2 and 4) driven by the same stimulus,
// each compared cycle by cycle against an interval-list model of the move profile.
module tb_step_ramp_gen;
    localparam int unsigned CNT_W  = 26;
    localparam int unsigned STEP_W = 16;
    localparam int          PW_A   = 2;
    localparam int          PW_B   = 4;

    typedef int iq_t[$];

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_cnt[2];
    logic exp_dir[2];

    always #5 clk = ~clk;

    step_ramp_gen_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus_a ();
    step_ramp_gen_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus_b ();

    assign bus_b.start       = bus_a.start;
    assign bus_b.dir_in      = bus_a.dir_in;
    assign bus_b.num_steps   = bus_a.num_steps;
    assign bus_b.period_init = bus_a.period_init;
    assign bus_b.period_min  = bus_a.period_min;
    assign bus_b.period_dec  = bus_a.period_dec;
    assign bus_b.abort       = bus_a.abort;

    step_ramp_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W), .PULSE_W(PW_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    step_ramp_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W), .PULSE_W(PW_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Interval lengths of a move, derived step by step from the profile rules.
    // mode: 0 accelerating, 1 cruising, 2 decelerating. Abort is a one-cycle pulse at abort_cyc.
    function automatic iq_t model(input int pw, input int num, input int init, input int pmin,
                                  input int dec, input int abort_cyc);
        iq_t    q;
        longint cur, ramp, t, e, fin, top;
        int     mode;
        if (num == 0) return q;
        top  = (init > pmin) ? init : pmin;
        cur  = top;
        mode = (cur == pmin) ? 1 : 0;
        ramp = 0;
        t    = 1;
        for (int n = 1; n <= num; n++) begin
            e   = (cur > pw + 1) ? cur : pw + 1;
            fin = t + e - 1;
            if (mode != 2 && abort_cyc >= t && abort_cyc < fin) mode = 2;
            q.push_back(int'(e));
            if (n == num || (mode == 2 && ramp == 0)) break;
            if (mode != 2 && num - n <= ramp) begin
                mode = 2;
                cur  = (cur + dec > top) ? top : cur + dec;
                ramp = (ramp > 0) ? ramp - 1 : 0;
            end else if (mode == 0) begin
                cur  = (cur - dec < pmin) ? pmin : cur - dec;
                ramp = ramp + 1;
                if (cur == pmin) mode = 1;
            end else if (mode == 2) begin
                cur  = (cur + dec > top) ? top : cur + dec;
                ramp = (ramp > 0) ? ramp - 1 : 0;
            end
            if (mode != 2 && abort_cyc == fin) mode = 2;
            t = fin + 1;
        end
        return q;
    endfunction

    function automatic int total(input iq_t iv);
        int s = 0;
        foreach (iv[k]) s += iv[k];
        return s;
    endfunction

    // Expected outputs in cycle c after acceptance (move occupies cycles 1..total).
    task automatic expect_at(input iq_t iv, input int pw, input int c, output logic e_step,
                             output logic e_busy, output logic e_done, output int e_cnt);
        int s = 1;
        e_step = 1'b0;
        e_cnt  = 0;
        foreach (iv[k]) begin
            if (c >= s && c < s + iv[k] && c - s < pw) e_step = 1'b1;
            if (c >= s + iv[k]) e_cnt = k + 1;
            s += iv[k];
        end
        e_busy = (c <= s - 1);
        e_done = (c == s);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at t=%0t: observed %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic e_step, input logic e_busy,
                             input logic e_done, input int e_cnt, input logic e_dir);
        string p = (d == 0) ? "pw2" : "pw4";
        logic  o_step, o_busy, o_done, o_dir;
        logic [STEP_W-1:0] o_cnt;
        if (d == 0) begin
            o_step = bus_a.step; o_busy = bus_a.busy; o_done = bus_a.done;
            o_dir  = bus_a.dir;  o_cnt  = bus_a.step_count;
        end else begin
            o_step = bus_b.step; o_busy = bus_b.busy; o_done = bus_b.done;
            o_dir  = bus_b.dir;  o_cnt  = bus_b.step_count;
        end
        chk({p, ".step"},       64'(o_step), 64'(e_step));
        chk({p, ".busy"},       64'(o_busy), 64'(e_busy));
        chk({p, ".done"},       64'(o_done), 64'(e_done));
        chk({p, ".step_count"}, 64'(o_cnt),  64'(e_cnt));
        chk({p, ".dir"},        64'(o_dir),  64'(e_dir));
    endtask

    task automatic drive_noise();
        bus_a.dir_in      = 1'($urandom);
        bus_a.num_steps   = STEP_W'($urandom);
        bus_a.period_init = CNT_W'($urandom);
        bus_a.period_min  = CNT_W'($urandom);
        bus_a.period_dec  = CNT_W'($urandom);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) check_dut(d, 1'b0, 1'b0, 1'b0, exp_cnt[d], exp_dir[d]);
            bus_a.start = 1'b0;
            bus_a.abort = 1'b0;
            drive_noise();
        end
    endtask

    // Called at a negedge (cycle 0); returns at the negedge of the done cycle (or after reset).
    task automatic run_move(input logic dirv, input int num, input int init, input int pmin,
                            input int dec, input int abort_cyc, input int rst_cyc,
                            input int busy_start_cyc);
        iq_t  iv[2];
        int   tot, last_c, e_cnt;
        logic e_step, e_busy, e_done;
        bit   acc = (num != 0);
        iv[0] = model(PW_A, num, init, pmin, dec, abort_cyc);
        iv[1] = model(PW_B, num, init, pmin, dec, abort_cyc);
        tot   = (total(iv[0]) > total(iv[1])) ? total(iv[0]) : total(iv[1]);
        bus_a.start       = 1'b1;
        bus_a.dir_in      = dirv;
        bus_a.num_steps   = STEP_W'(num);
        bus_a.period_init = CNT_W'(init);
        bus_a.period_min  = CNT_W'(pmin);
        bus_a.period_dec  = CNT_W'(dec);
        bus_a.abort       = (abort_cyc == 0);
        last_c = acc ? tot + 1 : 4;
        if (rst_cyc >= 0) last_c = rst_cyc + 3;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_cyc >= 0 && c > rst_cyc) begin
                    check_dut(d, 1'b0, 1'b0, 1'b0, 0, 1'b0);
                end else if (!acc) begin
                    check_dut(d, 1'b0, 1'b0, 1'b0, exp_cnt[d], exp_dir[d]);
                end else begin
                    expect_at(iv[d], (d == 0) ? PW_A : PW_B, c, e_step, e_busy, e_done, e_cnt);
                    check_dut(d, e_step, e_busy, e_done, e_cnt, dirv);
                end
            end
            bus_a.start = (c == busy_start_cyc);
            bus_a.abort = (c == abort_cyc);
            rst         = (c == rst_cyc);
            drive_noise();
        end
        for (int d = 0; d < 2; d++) begin
            if (rst_cyc >= 0) begin
                exp_cnt[d] = 0;
                exp_dir[d] = 1'b0;
            end else if (acc) begin
                exp_cnt[d] = iv[d].size();
                exp_dir[d] = dirv;
            end
        end
    endtask

    initial begin
        int   r_num, r_init, r_min, r_dec, r_abort;
        logic r_dir;
        rst               = 1'b1;
        bus_a.start       = 1'b0;
        bus_a.abort       = 1'b0;
        bus_a.dir_in      = 1'b0;
        bus_a.num_steps   = '0;
        bus_a.period_init = '0;
        bus_a.period_min  = '0;
        bus_a.period_dec  = '0;
        exp_cnt           = '{0, 0};
        exp_dir           = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b0;
        idle(2);

        // Constant speed, then a trapezoid started in the done cycle.
        run_move(1'b1, 4, 10, 10, 0, -1, -1, -1);
        run_move(1'b0, 6, 20, 10, 5, -1, -1, -1);
        idle(3);
        // Abort in cruise (3rd interval), abort in the 1st interval, abort on an interval end.
        run_move(1'b1, 100, 20, 10, 5, 40, -1, -1);
        idle(2);
        run_move(1'b0, 100, 20, 10, 5, 5, -1, -1);
        idle(2);
        run_move(1'b1, 100, 20, 10, 5, 20, -1, -1);
        idle(2);
        // Short move without cruise; zero-step request ignored.
        run_move(1'b1, 3, 20, 10, 5, -1, -1, -1);
        idle(2);
        run_move(1'b0, 0, 20, 10, 5, -1, -1, -1);
        idle(2);
        // Clamps: init below min, pulse-limited interval, oversized period_dec.
        run_move(1'b0, 5, 5, 8, 2, -1, -1, -1);
        idle(1);
        run_move(1'b1, 4, 3, 3, 0, -1, -1, -1);
        idle(1);
        run_move(1'b1, 7, 20, 3, 7, -1, -1, -1);
        idle(1);
        run_move(1'b0, 6, 12, 4, 50, -1, -1, -1);
        idle(1);
        // start+abort together in idle, start while busy, reset during the 2nd pulse.
        run_move(1'b1, 4, 10, 10, 0, 0, -1, -1);
        idle(1);
        run_move(1'b0, 6, 20, 10, 5, -1, -1, 8);
        idle(2);
        run_move(1'b1, 6, 20, 10, 5, -1, 21, -1);
        idle(3);

        for (int i = 0; i < 16; i++) begin
            r_num   = $urandom_range(0, 30);
            r_init  = $urandom_range(1, 30);
            r_min   = $urandom_range(0, 20);
            r_dec   = $urandom_range(0, 8);
            r_abort = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 300)) : -1;
            r_dir   = 1'($urandom_range(0, 1));
            run_move(r_dir, r_num, r_init, r_min, r_dec, r_abort, -1, -1);
            idle($urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
